// File: rtl/boot_loader_if.sv
// rtl/boot_loader_if.sv - ROM read / program-RAM write bundle between the loader and its memories
interface boot_loader_if #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 8
);
  logic [ADDRESS_BITS-1:0] ROM_ADDRESS;
  logic [BITS-1:0]         ROM_DATA;
  logic [ADDRESS_BITS-1:0] RAM_ADDRESS;
  logic [BITS-1:0]         RAM_DATA;
  logic                    RAM_WR;

  modport master (
    output ROM_ADDRESS,
    input  ROM_DATA,
    output RAM_ADDRESS,
    output RAM_DATA,
    output RAM_WR
  );

  modport slave (
    input  ROM_ADDRESS,
    output ROM_DATA,
    input  RAM_ADDRESS,
    input  RAM_DATA,
    input  RAM_WR
  );
endinterface

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - copies WORDS words from synchronous ROM into program RAM, then releases CPU reset
module boot_loader #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 8,
  parameter int WORDS        = 256
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  boot_loader_if.master   bus,
  output logic            BUSY,
  output logic            DONE,
  output logic            CPU_RESET,
  output logic [BITS-1:0] CHECKSUM
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COPY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Terminal address is compared before incrementing, so WORDS = 2**ADDRESS_BITS never wraps.
  localparam logic [ADDRESS_BITS-1:0] LAST_ADDRESS = ADDRESS_BITS'(WORDS - 1);

  logic [1:0] state;

  // ROM data arrives on the same edge the write strobe is registered, so no realignment is needed.
  assign bus.RAM_DATA = bus.ROM_DATA;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= S_IDLE;
      bus.ROM_ADDRESS <= '0;
      bus.RAM_ADDRESS <= '0;
      bus.RAM_WR      <= 1'b0;
      BUSY            <= 1'b0;
      DONE            <= 1'b0;
      CPU_RESET       <= 1'b1;
      CHECKSUM        <= '0;
    end else begin
      if (bus.RAM_WR) begin
        CHECKSUM <= CHECKSUM + bus.ROM_DATA;
      end
      case (state)
        S_IDLE: begin
          if (START) begin
            state           <= S_COPY;
            BUSY            <= 1'b1;
            CHECKSUM        <= '0;
            bus.ROM_ADDRESS <= '0;
          end
        end
        S_COPY: begin
          bus.RAM_ADDRESS <= bus.ROM_ADDRESS;
          bus.RAM_WR      <= 1'b1;
          if (bus.ROM_ADDRESS == LAST_ADDRESS) begin
            state           <= S_DRAIN;
            bus.ROM_ADDRESS <= '0;
          end else begin
            bus.ROM_ADDRESS <= bus.ROM_ADDRESS + ADDRESS_BITS'(1);
          end
        end
        S_DRAIN: begin
          state      <= S_DONE;
          bus.RAM_WR <= 1'b0;
          BUSY       <= 1'b0;
          DONE       <= 1'b1;
          CPU_RESET  <= 1'b0;
        end
        default: begin
          if (START) begin
            state     <= S_COPY;
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            CPU_RESET <= 1'b1;
            CHECKSUM  <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - directed bench for boot_loader across WORDS = 4, 1, 256 and 8
module tb_boot_loader;
  localparam int N = 4;

  function automatic int words_of(input int g);
    case (g)
      0:       return 4;
      1:       return 1;
      2:       return 256;
      default: return 8;
    endcase
  endfunction

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic           RST;
  logic           START;
  logic [N-1:0]   busy;
  logic [N-1:0]   done;
  logic [N-1:0]   cpu_reset;
  logic [15:0]    checksum [N];
  logic [15:0]    rom [N][256];
  int             n_tests = 0;
  int             n_fail  = 0;

  boot_loader_if #(.BITS(16), .ADDRESS_BITS(8)) bus [N] ();

  for (genvar g = 0; g < N; g++) begin : g_dut
    int          cnt = 0;
    int          err = 0;
    logic        prev_wr = 1'b0;
    logic [7:0]  prev_addr = '0;

    boot_loader #(.BITS(16), .ADDRESS_BITS(8), .WORDS(words_of(g))) dut (
      .CLK       (CLK),
      .RST       (RST),
      .START     (START),
      .bus       (bus[g].master),
      .BUSY      (busy[g]),
      .DONE      (done[g]),
      .CPU_RESET (cpu_reset[g]),
      .CHECKSUM  (checksum[g])
    );

    // Synchronous ROM: data registered one edge after the address is sampled.
    always @(posedge CLK) bus[g].ROM_DATA <= rom[g][bus[g].ROM_ADDRESS];

    // Every write must continue the 0,1,2,... run and carry the ROM word for its address.
    always @(negedge CLK) begin
      if (bus[g].RAM_WR) begin
        if (bus[g].RAM_ADDRESS != (prev_wr ? prev_addr + 8'd1 : 8'd0)) err++;
        if (bus[g].RAM_DATA != rom[g][bus[g].RAM_ADDRESS]) err++;
        cnt++;
      end
      prev_wr   = bus[g].RAM_WR;
      prev_addr = bus[g].RAM_ADDRESS;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  int s0, s1, s2, s3;
  int first_done [N];
  logic exp_done;

  initial begin
    for (int g = 0; g < N; g++)
      for (int i = 0; i < 256; i++) rom[g][i] = 16'h0000;
    for (int i = 0; i < 4; i++)   rom[0][i] = 16'(i + 1);
    rom[1][0] = 16'hBEEF;
    for (int i = 0; i < 256; i++) rom[2][i] = 16'hFFFF;
    for (int i = 0; i < 8; i++)   rom[3][i] = 16'(3 * i + 1);

    RST = 1'b1;
    START = 1'b0;
    repeat (3) tick;
    check("rst rom_addr", bus[0].ROM_ADDRESS, 0);
    check("rst ram_addr", bus[0].RAM_ADDRESS, 0);
    check("rst ram_wr", bus[0].RAM_WR, 0);
    check("rst busy", busy, 4'h0);
    check("rst done", done, 4'h0);
    check("rst cpu_reset", cpu_reset, 4'hF);
    check("rst checksum", checksum[2], 0);
    RST = 1'b0;
    tick;

    // Tests 1-3 (and WORDS=8) from one START pulse at edge 0
    s0 = g_dut[0].cnt; s1 = g_dut[1].cnt; s2 = g_dut[2].cnt; s3 = g_dut[3].cnt;
    for (int g = 0; g < N; g++) first_done[g] = 0;
    START = 1'b1;
    tick;
    START = 1'b0;
    check("start busy", busy, 4'hF);
    for (int c = 1; c <= 260; c++) begin
      tick;
      for (int g = 0; g < N; g++)
        if (done[g] && first_done[g] == 0) first_done[g] = c;
      if (c == 1) begin
        check("w4 c1 wr", bus[0].RAM_WR, 1);
        check("w4 c1 addr", bus[0].RAM_ADDRESS, 0);
        check("w4 c1 data", bus[0].RAM_DATA, 1);
      end
      if (c == 4) begin
        check("w4 c4 addr", bus[0].RAM_ADDRESS, 3);
        check("w4 c4 data", bus[0].RAM_DATA, 4);
        check("w4 c4 done", done[0], 0);
      end
      if (c == 5) check("w4 c5 wr", bus[0].RAM_WR, 0);
      if (c == 256) check("w256 last addr", bus[2].RAM_ADDRESS, 8'hFF);
    end
    check("w4 done cycle", first_done[0], 5);
    check("w1 done cycle", first_done[1], 2);
    check("w256 done cycle", first_done[2], 257);
    check("w8 done cycle", first_done[3], 9);
    check("w4 writes", g_dut[0].cnt - s0, 4);
    check("w1 writes", g_dut[1].cnt - s1, 1);
    check("w256 writes", g_dut[2].cnt - s2, 256);
    check("w8 writes", g_dut[3].cnt - s3, 8);
    check("w4 checksum", checksum[0], 16'h000A);
    check("w1 checksum", checksum[1], 16'hBEEF);
    check("w256 checksum", checksum[2], 16'hFF00);
    check("w8 checksum", checksum[3], 16'h005C);
    check("released cpu_reset", cpu_reset, 4'h0);
    check("busy clear", busy, 4'h0);

    // Test 4: re-copy from DONE, abort with RST sampled at edge 5
    s3 = g_dut[3].cnt;
    START = 1'b1;
    tick;
    START = 1'b0;
    check("recopy cpu_reset", cpu_reset[3], 1);
    check("recopy checksum clr", checksum[3], 0);
    repeat (4) tick;
    check("w8 c4 wr", bus[3].RAM_WR, 1);
    RST = 1'b1;
    tick;
    check("abort wr", bus[3].RAM_WR, 0);
    check("abort cpu_reset", cpu_reset[3], 1);
    check("abort done", done[3], 0);
    check("abort busy", busy[3], 0);
    check("abort checksum", checksum[3], 0);
    RST = 1'b0;
    repeat (5) tick;
    check("abort writes", g_dut[3].cnt - s3, 4);
    check("abort idle wr", bus[3].RAM_WR, 0);
    s3 = g_dut[3].cnt;
    START = 1'b1;
    tick;
    START = 1'b0;
    repeat (10) tick;
    check("after abort writes", g_dut[3].cnt - s3, 8);
    check("after abort done", done[3], 1);
    check("after abort checksum", checksum[3], 16'h005C);

    // Test 5: START held high, WORDS=4 -> DONE at cycles 5, 11, 17
    RST = 1'b1;
    tick;
    RST = 1'b0;
    tick;
    s0 = g_dut[0].cnt;
    START = 1'b1;
    tick;
    for (int c = 1; c <= 17; c++) begin
      tick;
      exp_done = (c >= 5) && ((c - 5) % 6 == 0);
      check($sformatf("held c%0d done", c), done[0], exp_done);
      check($sformatf("held c%0d cpu_reset", c), cpu_reset[0], !exp_done);
    end
    START = 1'b0;
    check("held writes", g_dut[0].cnt - s0, 12);

    // Test 6: START pulse during COPY is ignored
    RST = 1'b1;
    tick;
    RST = 1'b0;
    tick;
    s0 = g_dut[0].cnt;
    first_done[0] = 0;
    START = 1'b1;
    tick;
    START = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (done[0] && first_done[0] == 0) first_done[0] = c;
      if (c == 2) START = 1'b1;
      if (c == 3) START = 1'b0;
    end
    check("mid start done cycle", first_done[0], 5);
    check("mid start writes", g_dut[0].cnt - s0, 4);
    check("mid start checksum", checksum[0], 16'h000A);

    check("monitor errors", g_dut[0].err + g_dut[1].err + g_dut[2].err + g_dut[3].err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
